// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types, sizes and helpers for the thread dispatch sequencer.
package dispatch_pkg;
  localparam int NUM_LANES = 4;
  localparam int TID_W = 10;
  localparam int CHUNK_W = 256;
  localparam int NUM_CHUNKS = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int MASK_W = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = $clog2(NUM_CHUNKS);
  localparam int CNT_W = $clog2(CHUNK_W + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SELECT, RESTART, SETTLE, RUN, DRAIN} state_e;
  typedef struct packed {
    logic [NUM_LANES-1:0][TID_W-1:0] tid;
    logic [NUM_LANES-1:0] lane_mask;
    logic last;
  } bundle_t;
  function automatic logic [CNT_W-1:0] popcnt(input logic [CHUNK_W-1:0] v);
    popcnt = '0;
    for (int i = 0; i < CHUNK_W; i++) popcnt = popcnt + CNT_W'(v[i]);
  endfunction
endpackage

// File: rtl/thread_dispatch_sequencer_if.sv
// thread_dispatch_sequencer_if: valid/ready bundle bus towards the CGRA issue stage.
interface thread_dispatch_sequencer_if;
  import dispatch_pkg::*;
  logic disp_valid;
  logic disp_ready;
  logic [NUM_LANES*TID_W-1:0] disp_tid;
  logic [NUM_LANES-1:0] disp_lane_mask;
  logic disp_last;
  modport master(output disp_valid, disp_tid, disp_lane_mask, disp_last, input disp_ready);
  modport slave(input disp_valid, disp_tid, disp_lane_mask, disp_last, output disp_ready);
endinterface

// File: rtl/dispatch_out_reg.sv
// dispatch_out_reg: one-entry valid/ready holding register for outgoing bundles.
module dispatch_out_reg
  import dispatch_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  input  logic    load,
  input  bundle_t in_bundle,
  input  logic    ready,
  output logic    valid,
  output bundle_t out_bundle
);
  logic valid_q, valid_d;
  bundle_t data_q, data_d;
  always_comb begin
    valid_d = flush ? 1'b0 : load ? 1'b1 : valid_q && !ready;
    data_d = (load && !flush) ? in_bundle : data_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  assign valid = valid_q;
  assign out_bundle = data_q;
endmodule

// File: rtl/thread_dispatch_sequencer.sv
// thread_dispatch_sequencer: walks a warp mask chunk by chunk, drives the thread generator
// and issues its TID bundles to the issue stage.
module thread_dispatch_sequencer
  import dispatch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [MASK_W-1:0]   active_mask,
  input  logic [1:0]          unrolling_factor_in,
  output logic                busy,
  output logic                done,
  output logic [CHUNK_W-1:0]  active_mask_chunk,
  output logic [IDX_W-1:0]    chunk_base_addr,
  output logic [1:0]          unrolling_factor,
  output logic                restart,
  output logic                fifo_pop,
  input  logic [TID_W-1:0]    next_tid_0,
  input  logic [TID_W-1:0]    next_tid_1,
  input  logic [TID_W-1:0]    next_tid_2,
  input  logic [TID_W-1:0]    next_tid_3,
  input  logic                valid_0,
  input  logic                valid_1,
  input  logic                valid_2,
  input  logic                valid_3,
  input  logic                fifo_empty,
  input  logic                chunk_done,
  thread_dispatch_sequencer_if.master disp
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CHUNK_W-1:0] chunk_q, chunk_d;
  logic [1:0] uf_q, uf_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] remain_q, remain_d, lane_cnt;
  logic final_q, final_d;
  logic [NUM_LANES-1:0] lanes;
  logic out_valid, load;
  bundle_t in_b, out_b;
  assign lanes = {valid_3, valid_2, valid_1, valid_0};
  assign lane_cnt = CNT_W'(valid_0) + CNT_W'(valid_1) + CNT_W'(valid_2) + CNT_W'(valid_3);
  assign fifo_pop = state_q == RUN && !fifo_empty && (!out_valid || disp.disp_ready) && !abort;
  assign load = fifo_pop && |lanes;
  // remain_q counts threads still owed by this chunk, so the final one can be tagged at pop time
  assign in_b = {next_tid_3, next_tid_2, next_tid_1, next_tid_0, lanes, final_q && remain_q == lane_cnt};
  assign busy = state_q != IDLE;
  assign restart = state_q == RESTART;
  assign done = state_q == DRAIN && !out_valid && !abort;
  assign active_mask_chunk = chunk_q;
  assign chunk_base_addr = idx_q;
  assign unrolling_factor = uf_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    mask_d = mask_q;
    uf_d = uf_q;
    settle_d = settle_q;
    remain_d = remain_q;
    final_d = final_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SELECT;
        mask_d = active_mask;
        uf_d = unrolling_factor_in;
        idx_d = '0;
      end
      SELECT: begin
        remain_d = popcnt(chunk_q);
        final_d = (mask_q >> ((32'(idx_q) + 32'd1) * CHUNK_W)) == '0;
        if (chunk_q != '0) state_d = RESTART;
        else if (idx_q == IDX_W'(NUM_CHUNKS - 1)) state_d = DRAIN;
        else idx_d = idx_q + 1'b1;
      end
      RESTART: begin
        state_d = SETTLE;
        settle_d = SET_W'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (settle_q == '0) state_d = RUN; else settle_d = settle_q - 1'b1;
      RUN: begin
        if (fifo_pop) remain_d = remain_q - lane_cnt;
        if (chunk_done && fifo_empty) begin
          if (idx_q == IDX_W'(NUM_CHUNKS - 1)) state_d = DRAIN;
          else begin
            idx_d = idx_q + 1'b1;
            state_d = SELECT;
          end
        end
      end
      DRAIN: if (!out_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    chunk_d = mask_d[{idx_d, {$clog2(CHUNK_W){1'b0}}} +: CHUNK_W];
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      mask_q <= '0;
      chunk_q <= '0;
      uf_q <= '0;
      settle_q <= '0;
      remain_q <= '0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
      chunk_q <= chunk_d;
      uf_q <= uf_d;
      settle_q <= settle_d;
      remain_q <= remain_d;
      final_q <= final_d;
    end
  dispatch_out_reg u_out (
    .clk(clk),
    .rst_n(rst_n),
    .flush(abort),
    .load(load),
    .in_bundle(in_b),
    .ready(disp.disp_ready),
    .valid(out_valid),
    .out_bundle(out_b)
  );
  assign disp.disp_valid = out_valid;
  assign disp.disp_tid = out_b.tid;
  assign disp.disp_lane_mask = out_b.lane_mask;
  assign disp.disp_last = out_b.last;
endmodule
